exception_vector_fetch: RTL and testbench
=========================================

Name: exception_vector_fetch

Overview:
- Multicycle sequencer upstream of the memory-address-source mux.
- On a CPU exception (invalid opcode, ALU overflow, divide-by-zero) it does three things:
  - saves EPC;
  - drives the mux select to the matching fixed vector address (253/254/255) and waits for the memory read;
  - loads PC with the zero-extended handler byte.
- While active, it owns the mux select, PC write and EPC write; the main control unit is stalled.

Parameters:
- MEM_LAT, 1, cycles from address presentation to valid mem_rdata (1..7).
- EPC_OFFSET, 4, value subtracted from pc_in to form EPC (PC already incremented at fetch).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low (reset==0 resets on the rising edge).
- exc_opcode  in  1  invalid-opcode pulse from control unit.
- exc_overflow  in  1  ALU overflow pulse.
- exc_divzero  in  1  divide-by-zero pulse.
- pc_in  in  32  current PC register value.
- mem_rdata  in  32  memory read data.
- mem_adrs_src  out  3  mux select: 000 PC, 010 vec253, 011 vec254, 100 vec255.
- own_bus  out  1  high while this block drives select/PC/EPC; control unit stalls.
- epc_wr  out  1  one-cycle EPC write strobe.
- epc_out  out  32  pc_in − EPC_OFFSET, registered.
- pc_wr  out  1  one-cycle PC write strobe.
- pc_next  out  32  {24'b0, mem_rdata[7:0]}, registered.
- cause  out  2  00 none, 01 opcode, 10 overflow, 11 divzero; holds last serviced cause.

Behaviour:
- Reset values:
  - state=IDLE, mem_adrs_src=000;
  - own_bus, epc_wr and pc_wr all 0;
  - epc_out, pc_next and cause all 0;
  - wait counter = 0.
- Priority when several exc_* are high in the same cycle: opcode > overflow > divzero. Lower-priority events in that cycle are dropped.
- IDLE: select=000, own_bus=0. Any exc_* high → CAPTURE on the next edge; latch cause, and latch epc_out = pc_in − EPC_OFFSET (32-bit wrap, no saturation).
- CAPTURE (1 cycle): own_bus=1, epc_wr=1, select = vector code for cause; counter loaded with MEM_LAT → WAIT.
- WAIT: select held, own_bus=1. Counter decrements each cycle. At 1, the next edge registers pc_next from mem_rdata[7:0] → JUMP.
- JUMP (1 cycle): pc_wr=1, own_bus=1, select held → IDLE.
- Total latency from exception edge to pc_wr asserted: MEM_LAT+2 cycles.
- exc_* asserted in any non-IDLE state is ignored (unless EXC_PENDING_EN).
- reset=0 in any state: return to IDLE with reset values on that edge. No partial strobes are emitted afterwards.
- pc_next is always zero-extended; the handler range is 0..255.
- epc_wr and pc_wr are never high in the same cycle.

Optional Feature:
- Macro EXC_PENDING_EN.
- Defined:
  - one-deep pending register captures the highest-priority exc_* seen while not in IDLE;
  - the first one captured wins, later ones are dropped;
  - leaving JUMP with pending set goes directly to CAPTURE using the pending cause, then clears pending;
  - epc_out is recomputed from pc_in in that cycle (which already holds the first handler address).
  - Extra output pend_ovf (1 bit, sticky until reset) flags events dropped while pending was full.
- Undefined: behaviour as above; no pending register; pend_ovf absent.

Decomposition:
- Package exc_pkg:
  - state enum (IDLE, CAPTURE, WAIT, JUMP);
  - cause codes;
  - select codes SEL_PC=3'b000, SEL_V253=3'b010, SEL_V254=3'b011, SEL_V255=3'b100;
  - function cause_to_sel.
- Sub-module exc_prio_enc: combinational 3-input priority encoder giving valid + cause.
  - Reused for the pending register.

Test Plan:
- Reset held low 3 cycles, then released → all outputs 0, select=000 before any exception.
- exc_overflow pulse with pc_in=0x0000_0040, mem_rdata=0x0000_00A5, MEM_LAT=1:
  - epc_wr at cycle+1 with epc_out=0x3C;
  - select=011 for cycles +1..+2;
  - pc_wr at cycle+3 with pc_next=0xA5;
  - cause=10.
- exc_opcode, exc_overflow and exc_divzero all asserted in the same cycle → select=010, cause=01; no second sequence.
- MEM_LAT=3, exc_divzero, mem_rdata=0xFFFF_FF7E → select=100 for 4 cycles, pc_wr at cycle+5, pc_next=0x7E.
- pc_in=0x0000_0002, exc_opcode → epc_out=0xFFFF_FFFE (wrap).
- reset=0 during WAIT → no pc_wr; next cycle is IDLE with select=000.
- With EXC_PENDING_EN: exc_opcode, then exc_divzero during WAIT, then exc_overflow → second CAPTURE immediately after JUMP with cause=11; pend_ovf=1.

Source files
------------

// File: rtl/exc_pkg.sv
// Shared types for the exception vector fetch sequencer: FSM states, cause
// codes, address-mux select codes and the cause-to-select mapping.
package exc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    WAIT    = 2'd2,
    JUMP    = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'b00,
    CAUSE_OPCODE = 2'b01,
    CAUSE_OVF    = 2'b10,
    CAUSE_DIVZ   = 2'b11
  } cause_e;

  localparam logic [2:0] SEL_PC   = 3'b000;
  localparam logic [2:0] SEL_V253 = 3'b010;
  localparam logic [2:0] SEL_V254 = 3'b011;
  localparam logic [2:0] SEL_V255 = 3'b100;

  function automatic logic [2:0] cause_to_sel(input cause_e c);
    case (c)
      CAUSE_OPCODE: cause_to_sel = SEL_V253;
      CAUSE_OVF:    cause_to_sel = SEL_V254;
      CAUSE_DIVZ:   cause_to_sel = SEL_V255;
      default:      cause_to_sel = SEL_PC;
    endcase
  endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Three-input exception priority encoder: opcode > overflow > divzero.
module exc_prio_enc
  import exc_pkg::*;
(
  input  logic   exc_opcode_i,
  input  logic   exc_overflow_i,
  input  logic   exc_divzero_i,
  output logic   vld_o,
  output cause_e cause_o
);

  always_comb begin
    vld_o   = exc_opcode_i | exc_overflow_i | exc_divzero_i;
    cause_o = CAUSE_NONE;
    if (exc_opcode_i)        cause_o = CAUSE_OPCODE;
    else if (exc_overflow_i) cause_o = CAUSE_OVF;
    else if (exc_divzero_i)  cause_o = CAUSE_DIVZ;
  end

endmodule

// File: rtl/exception_vector_fetch.sv
// Exception vector fetch sequencer: saves EPC, selects the vector address,
// waits MEM_LAT cycles for the handler byte and loads it into PC.
// Optional EXC_PENDING_EN adds a one-deep pending exception and pend_ovf.
module exception_vector_fetch
  import exc_pkg::*;
#(
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned EPC_OFFSET = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_divzero,
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_rdata,
  output logic [2:0]  mem_adrs_src,
  output logic        own_bus,
  output logic        epc_wr,
  output logic [31:0] epc_out,
  output logic        pc_wr,
  output logic [31:0] pc_next,
  output logic [1:0]  cause
`ifdef EXC_PENDING_EN
  ,
  output logic        pend_ovf
`endif
);

  localparam logic [2:0]  LAT = 3'(MEM_LAT);
  localparam logic [31:0] OFS = 32'(EPC_OFFSET);

  state_e      state_q, state_d;
  cause_e      cause_q, cause_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] pcn_q, pcn_d;
  logic        enc_vld;
  cause_e      enc_cause;
  logic        unused_rdata;

  assign unused_rdata = ^mem_rdata[31:8];

  exc_prio_enc u_enc (
    .exc_opcode_i  (exc_opcode),
    .exc_overflow_i(exc_overflow),
    .exc_divzero_i (exc_divzero),
    .vld_o         (enc_vld),
    .cause_o       (enc_cause)
  );

`ifdef EXC_PENDING_EN
  logic   pend_vld_q, pend_vld_d;
  cause_e pend_cause_q, pend_cause_d;
  logic   pend_ovf_q, pend_ovf_d;
  assign pend_ovf = pend_ovf_q;
`endif

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    cnt_d   = cnt_q;
    epc_d   = epc_q;
    pcn_d   = pcn_q;
`ifdef EXC_PENDING_EN
    pend_vld_d   = pend_vld_q;
    pend_cause_d = pend_cause_q;
    pend_ovf_d   = pend_ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (enc_vld) begin
          state_d = CAPTURE;
          cause_d = enc_cause;
          epc_d   = pc_in - OFS;
        end
      end
      CAPTURE: begin
        cnt_d   = LAT;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q <= 3'd1) begin
          pcn_d   = {24'b0, mem_rdata[7:0]};
          state_d = JUMP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      JUMP: begin
        state_d = IDLE;
`ifdef EXC_PENDING_EN
        // An event arriving in JUMP with pending empty is taken directly,
        // as if it had been parked and consumed on the same edge.
        if (pend_vld_q) begin
          state_d    = CAPTURE;
          cause_d    = pend_cause_q;
          epc_d      = pc_in - OFS;
          pend_vld_d = 1'b0;
        end else if (enc_vld) begin
          state_d = CAPTURE;
          cause_d = enc_cause;
          epc_d   = pc_in - OFS;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
`ifdef EXC_PENDING_EN
    if (enc_vld && state_q != IDLE) begin
      if (pend_vld_q) begin
        pend_ovf_d = 1'b1;
      end else if (state_q != JUMP) begin
        pend_vld_d   = 1'b1;
        pend_cause_d = enc_cause;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cause_q <= CAUSE_NONE;
      cnt_q   <= 3'd0;
      epc_q   <= 32'd0;
      pcn_q   <= 32'd0;
`ifdef EXC_PENDING_EN
      pend_vld_q   <= 1'b0;
      pend_cause_q <= CAUSE_NONE;
      pend_ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
      epc_q   <= epc_d;
      pcn_q   <= pcn_d;
`ifdef EXC_PENDING_EN
      pend_vld_q   <= pend_vld_d;
      pend_cause_q <= pend_cause_d;
      pend_ovf_q   <= pend_ovf_d;
`endif
    end
  end

  // Strobes and select decode straight from the registered state.
  assign own_bus      = (state_q != IDLE);
  assign epc_wr       = (state_q == CAPTURE);
  assign pc_wr        = (state_q == JUMP);
  assign mem_adrs_src = (state_q == IDLE) ? SEL_PC : cause_to_sel(cause_q);
  assign epc_out      = epc_q;
  assign pc_next      = pcn_q;
  assign cause        = cause_q;

endmodule

// File: tb/tb_exception_vector_fetch.sv
// Scoreboard bench: two DUTs (MEM_LAT=1 and MEM_LAT=3) share data inputs;
// expected sequences are queued at stimulus time and checked by a monitor.
module tb_exception_vector_fetch;

  typedef struct {
    logic [31:0] epc;
    logic [31:0] pcn;
    logic [1:0]  cause;
    logic [2:0]  sel;
    int          lat;
    bit          abort;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  exc0, exc1;  // {divzero, overflow, opcode}
  logic [31:0] pc_in, mem_rdata;

  logic [2:0]  sel [2];
  logic [1:0]  ob, ew, pw;
  logic [31:0] eo [2];
  logic [31:0] pn [2];
  logic [1:0]  ca [2];
`ifdef EXC_PENDING_EN
  logic [1:0]  povf;
`endif

  exp_t q0[$];
  exp_t q1[$];
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  exception_vector_fetch #(.MEM_LAT(1), .EPC_OFFSET(4)) u_dut0 (
    .clk(clk), .reset(reset),
    .exc_opcode(exc0[0]), .exc_overflow(exc0[1]), .exc_divzero(exc0[2]),
    .pc_in(pc_in), .mem_rdata(mem_rdata),
    .mem_adrs_src(sel[0]), .own_bus(ob[0]), .epc_wr(ew[0]), .epc_out(eo[0]),
    .pc_wr(pw[0]), .pc_next(pn[0]), .cause(ca[0])
`ifdef EXC_PENDING_EN
    , .pend_ovf(povf[0])
`endif
  );

  exception_vector_fetch #(.MEM_LAT(3), .EPC_OFFSET(4)) u_dut1 (
    .clk(clk), .reset(reset),
    .exc_opcode(exc1[0]), .exc_overflow(exc1[1]), .exc_divzero(exc1[2]),
    .pc_in(pc_in), .mem_rdata(mem_rdata),
    .mem_adrs_src(sel[1]), .own_bus(ob[1]), .epc_wr(ew[1]), .epc_out(eo[1]),
    .pc_wr(pw[1]), .pc_next(pn[1]), .cause(ca[1])
`ifdef EXC_PENDING_EN
    , .pend_ovf(povf[1])
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic push(input int d, input logic [31:0] epc, input logic [31:0] pcn,
                      input logic [1:0] c, input logic [2:0] s, input int lat, input bit ab);
    exp_t e;
    e.epc = epc; e.pcn = pcn; e.cause = c; e.sel = s; e.lat = lat; e.abort = ab;
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic pulse(input int d, input logic [2:0] v);
    @(posedge clk); #1;
    if (d == 0) exc0 = v; else exc1 = v;
    @(posedge clk); #1;
    exc0 = 3'b0; exc1 = 3'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: follows each sequence from epc_wr to pc_wr per DUT.
  int   act_m [2] = '{0, 0};
  int   cyc_m [2] = '{0, 0};
  exp_t cur   [2];
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        if (act_m[i] != 0) begin
          chk($sformatf("abort_expected%0d", i), 32'(cur[i].abort), 32'd1);
          act_m[i] = 0;
        end
      end else begin
        chk($sformatf("strobe_overlap%0d", i), 32'(ew[i] & pw[i]), 32'd0);
        if (ew[i]) begin
          if ((i == 0 ? q0.size() : q1.size()) == 0) begin
            chk($sformatf("unexpected_epc_wr%0d", i), 32'(ew[i]), 32'd0);
          end else begin
            if (i == 0) cur[i] = q0.pop_front();
            else        cur[i] = q1.pop_front();
            act_m[i] = 1;
            cyc_m[i] = 1;
            chk($sformatf("epc_out%0d", i), eo[i], cur[i].epc);
            chk($sformatf("cause%0d", i), 32'(ca[i]), 32'(cur[i].cause));
            chk($sformatf("sel_capture%0d", i), 32'(sel[i]), 32'(cur[i].sel));
            chk($sformatf("own_bus_capture%0d", i), 32'(ob[i]), 32'd1);
          end
        end else if (act_m[i] != 0) begin
          cyc_m[i]++;
          chk($sformatf("sel_held%0d", i), 32'(sel[i]), 32'(cur[i].sel));
          chk($sformatf("own_bus_held%0d", i), 32'(ob[i]), 32'd1);
          if (pw[i]) begin
            chk($sformatf("pc_wr_latency%0d", i), 32'(cyc_m[i]), 32'(cur[i].lat + 2));
            chk($sformatf("pc_next%0d", i), pn[i], cur[i].pcn);
            chk($sformatf("pc_wr_after_abort%0d", i), 32'(cur[i].abort), 32'd0);
            act_m[i] = 0;
          end else if (cyc_m[i] > cur[i].lat + 2) begin
            chk($sformatf("pc_wr_timeout%0d", i), 32'(cyc_m[i]), 32'(cur[i].lat + 2));
            act_m[i] = 0;
          end
        end else begin
          chk($sformatf("stray_pc_wr%0d", i), 32'(pw[i]), 32'd0);
        end
      end
    end
  end

  initial begin
    reset = 1'b0; exc0 = 3'b0; exc1 = 3'b0; pc_in = 32'd0; mem_rdata = 32'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_sel%0d", i), 32'(sel[i]), 32'd0);
      chk($sformatf("rst_own_bus%0d", i), 32'(ob[i]), 32'd0);
      chk($sformatf("rst_epc_out%0d", i), eo[i], 32'd0);
      chk($sformatf("rst_pc_next%0d", i), pn[i], 32'd0);
      chk($sformatf("rst_cause%0d", i), 32'(ca[i]), 32'd0);
    end

    // Overflow, MEM_LAT=1
    pc_in = 32'h0000_0040; mem_rdata = 32'h0000_00A5;
    push(0, 32'h0000_003C, 32'h0000_00A5, 2'b10, 3'b011, 1, 0);
    pulse(0, 3'b010);
    idle(8);

    // All three at once: opcode wins, others dropped
    pc_in = 32'h0000_0100; mem_rdata = 32'h1234_5611;
    push(0, 32'h0000_00FC, 32'h0000_0011, 2'b01, 3'b010, 1, 0);
    pulse(0, 3'b111);
    idle(8);
    chk("cause_holds", 32'(ca[0]), 32'd1);

    // Divzero, MEM_LAT=3, upper rdata bits discarded
    pc_in = 32'h0000_0200; mem_rdata = 32'hFFFF_FF7E;
    push(1, 32'h0000_01FC, 32'h0000_007E, 2'b11, 3'b100, 3, 0);
    pulse(1, 3'b100);
    idle(10);

    // EPC wrap below zero
    pc_in = 32'h0000_0002; mem_rdata = 32'h0000_0033;
    push(0, 32'hFFFF_FFFE, 32'h0000_0033, 2'b01, 3'b010, 1, 0);
    pulse(0, 3'b001);
    idle(8);

    // Reset during WAIT: sequence must be abandoned
    pc_in = 32'h0000_0080; mem_rdata = 32'h0000_0044;
    push(1, 32'h0000_007C, 32'h0000_0044, 2'b10, 3'b011, 3, 1);
    pulse(1, 3'b010);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("post_reset_sel", 32'(sel[1]), 32'd0);
    chk("post_reset_own_bus", 32'(ob[1]), 32'd0);
    chk("post_reset_epc_out", eo[1], 32'd0);
    chk("post_reset_cause", 32'(ca[1]), 32'd0);
    idle(8);

`ifdef EXC_PENDING_EN
    // Opcode, then divzero parked as pending, then overflow overflows it
    pc_in = 32'h0000_0300; mem_rdata = 32'h0000_005A;
    push(1, 32'h0000_02FC, 32'h0000_005A, 2'b01, 3'b010, 3, 0);
    push(1, 32'h0000_02FC, 32'h0000_005A, 2'b11, 3'b100, 3, 0);
    pulse(1, 3'b001);
    pulse(1, 3'b100);
    pulse(1, 3'b010);
    idle(16);
    chk("pend_ovf1", 32'(povf[1]), 32'd1);
    chk("pend_ovf0", 32'(povf[0]), 32'd0);
`endif

    chk("queue_drained", 32'(q0.size() + q1.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
